// File: rtl/attempt_a_checker_pkg.sv
// attempt_a_checker_pkg: shared game state encoding, seven-segment hint codes and pin widths
package attempt_a_checker_pkg;
  typedef enum logic [2:0] {IDLE, WAIT, CHECK, DONE, FAIL} state_t;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_H     = 8'h89;
  localparam logic [7:0] SEG_L     = 8'hC7;
  localparam logic [7:0] SEG_P     = 8'h8C;
  localparam logic [7:0] SEG_F     = 8'h8E;
  localparam int A_W = 4;
  localparam int B_W = 3;
endpackage

// File: rtl/attempt_a_checker_key_edge_sync.sv
// key_edge_sync: two-flop synchronizer with one-cycle rising-edge strobe for a raw key
module key_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic rise
);
  logic sync1, sync2, prev;
  always_ff @(posedge clk)
    if (rst) {sync1, sync2, prev} <= '0;
    else {sync1, sync2, prev} <= {key, sync1, sync2};
  assign rise = sync2 & ~prev;
endmodule

// File: rtl/attempt_a_checker.sv
// attempt_a_checker: pin A guess checker with H/L hints, error count, lock-out and done handshake
module attempt_a_checker
  import attempt_a_checker_pkg::*;
#(
  parameter int MAX_ERRORS = 3
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           Start,
  input  logic           Enter,
  input  logic           Time_Over,
  input  logic [A_W-1:0] Switches_Attempt,
  input  logic [A_W-1:0] A_Pin,
  output logic [A_W-1:0] Attempt,
  output logic           A_Done,
  output logic           Wrong_Pulse,
  output logic [1:0]     Errors,
  output logic           Locked_Out,
  output logic [7:0]     Display
);
  localparam logic [1:0] MAX_E = 2'(MAX_ERRORS);
  state_t state, state_n;
  logic [A_W-1:0] attempt_n;
  logic [1:0] err_n, err_inc;
  logic [7:0] disp_n;
  logic done_n, pulse_n, lock_n, enter_rise;
  key_edge_sync u_enter (.clk(Clk), .rst(Reset), .key(Enter), .rise(enter_rise));
  always_comb begin
    state_n = state;
    attempt_n = Attempt;
    done_n = A_Done;
    pulse_n = 1'b0;
    err_n = Errors;
    lock_n = Locked_Out;
    disp_n = Display;
    err_inc = (Errors == MAX_E) ? Errors : Errors + 2'd1;
    case (state)
      IDLE: if (Start) begin
        state_n = WAIT;
        disp_n = SEG_DASH;
      end
      WAIT, CHECK: if (!Start) begin
        state_n = IDLE;
        attempt_n = '0;
        err_n = '0;
        disp_n = SEG_BLANK;
      end else if (Time_Over) begin
        state_n = FAIL;
        lock_n = 1'b1;
        disp_n = SEG_F;
      end else if (state == WAIT) begin
        if (enter_rise) begin
          attempt_n = Switches_Attempt;
          state_n = CHECK;
        end
      end else if (Attempt == A_Pin) begin
        state_n = DONE;
        done_n = 1'b1;
        disp_n = SEG_P;
      end else begin
        pulse_n = 1'b1;
        err_n = err_inc;
        lock_n = (err_inc == MAX_E);
        state_n = (err_inc == MAX_E) ? FAIL : WAIT;
        disp_n = (err_inc == MAX_E) ? SEG_F : (Attempt > A_Pin) ? SEG_H : SEG_L;
      end
      default: ;
    endcase
  end
  always_ff @(posedge Clk)
    if (Reset) begin
      state <= IDLE;
      Attempt <= '0;
      A_Done <= 1'b0;
      Wrong_Pulse <= 1'b0;
      Errors <= '0;
      Locked_Out <= 1'b0;
      Display <= SEG_BLANK;
    end else begin
      state <= state_n;
      Attempt <= attempt_n;
      A_Done <= done_n;
      Wrong_Pulse <= pulse_n;
      Errors <= err_n;
      Locked_Out <= lock_n;
      Display <= disp_n;
    end
endmodule

// File: tb/tb_attempt_a_checker.sv
// tb_attempt_a_checker: randomized and directed self-checking bench against a behavioural model
module tb_attempt_a_checker;
  localparam int MAX_E = 3;
  logic Clk = 1'b0, Reset = 1'b1, Start = 1'b0, Enter = 1'b0, Time_Over = 1'b0;
  logic [3:0] Switches_Attempt = '0, A_Pin = '0, Attempt;
  logic A_Done, Wrong_Pulse, Locked_Out;
  logic [1:0] Errors;
  logic [7:0] Display;
  int n_cmp = 0, n_bad = 0;
  bit chk_en = 1'b0;
  bit h0, h1, h2, rise;
  bit m_done, m_lock, m_pend, m_act, m_pulse;
  int m_err;
  logic [3:0] m_att = '0;
  logic [7:0] m_disp = 8'hFF;

  attempt_a_checker #(.MAX_ERRORS(MAX_E)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Enter(Enter), .Time_Over(Time_Over),
    .Switches_Attempt(Switches_Attempt), .A_Pin(A_Pin), .Attempt(Attempt), .A_Done(A_Done),
    .Wrong_Pulse(Wrong_Pulse), .Errors(Errors), .Locked_Out(Locked_Out), .Display(Display)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: h0/h1/h2 hold the last three Enter samples; a press is seen once
  // the sample from two edges ago is high and the one before it was low.
  always @(posedge Clk) begin
    rise = h1 & ~h2;
    m_pulse = 1'b0;
    if (Reset) begin
      {h0, h1, h2} = '0;
      {m_done, m_lock, m_pend, m_act} = '0;
      m_att = '0;
      m_err = 0;
      m_disp = 8'hFF;
    end else begin
      h2 = h1; h1 = h0; h0 = Enter;
      if (m_done || m_lock) begin
      end else if ((m_pend || m_act) && !Start) begin
        {m_pend, m_act} = '0;
        m_att = '0;
        m_err = 0;
        m_disp = 8'hFF;
      end else if ((m_pend || m_act) && Time_Over) begin
        {m_pend, m_act} = '0;
        m_lock = 1'b1;
        m_disp = 8'h8E;
      end else if (m_pend) begin
        m_pend = 1'b0;
        if (m_att == A_Pin) begin
          m_done = 1'b1;
          m_disp = 8'h8C;
        end else begin
          m_pulse = 1'b1;
          m_err = (m_err + 1 > MAX_E) ? MAX_E : m_err + 1;
          if (m_err == MAX_E) begin
            m_lock = 1'b1;
            m_disp = 8'h8E;
          end else begin
            m_act = 1'b1;
            m_disp = (m_att > A_Pin) ? 8'h89 : 8'hC7;
          end
        end
      end else if (m_act) begin
        if (rise) begin
          m_att = Switches_Attempt;
          m_act = 1'b0;
          m_pend = 1'b1;
        end
      end else if (Start) begin
        m_act = 1'b1;
        m_disp = 8'hBF;
      end
    end
  end

  always @(negedge Clk)
    if (chk_en) begin
      chk("attempt", 8'(Attempt), 8'(m_att));
      chk("a_done", 8'(A_Done), 8'(m_done));
      chk("wrong_pulse", 8'(Wrong_Pulse), 8'(m_pulse));
      chk("errors", 8'(Errors), 8'(m_err));
      chk("locked_out", 8'(Locked_Out), 8'(m_lock));
      chk("display", Display, m_disp);
    end

  task automatic guess(input logic [3:0] g);
    Switches_Attempt = g;
    Enter = 1'b1;
    @(negedge Clk);
    Enter = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic restart(input logic [3:0] pin);
    Reset = 1'b1;
    Start = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    A_Pin = pin;
    Start = 1'b1;
    @(negedge Clk);
  endtask

  initial begin
    repeat (2) @(negedge Clk);
    chk_en = 1'b1;
    chk("rst_display", Display, 8'hFF);
    chk("rst_errors", 8'(Errors), 8'd0);
    Reset = 1'b0;
    A_Pin = 4'h9;
    Start = 1'b1;
    @(negedge Clk);
    chk("start_dash", Display, 8'hBF);
    Switches_Attempt = 4'h9;
    Enter = 1'b1;
    @(negedge Clk);
    Enter = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    chk("lat_attempt_k2", 8'(Attempt), 8'h09);
    chk("lat_done_k2", 8'(A_Done), 8'd0);
    @(negedge Clk);
    chk("lat_done_k3", 8'(A_Done), 8'd1);
    chk("lat_disp_p", Display, 8'h8C);
    chk("lat_err0", 8'(Errors), 8'd0);
    chk("lat_nopulse", 8'(Wrong_Pulse), 8'd0);
    Reset = 1'b1;
    @(negedge Clk);
    chk("done_reset", 8'(A_Done), 8'd0);
    chk("done_reset_disp", Display, 8'hFF);
    Start = 1'b0;
    Reset = 1'b0;
    @(negedge Clk);
    restart(4'h5);
    guess(4'h7);
    chk("hint_h", Display, 8'h89);
    chk("hint_h_err", 8'(Errors), 8'd1);
    chk("hint_h_pulse", 8'(Wrong_Pulse), 8'd1);
    @(negedge Clk);
    chk("pulse_one_cycle", 8'(Wrong_Pulse), 8'd0);
    chk("hint_persist", Display, 8'h89);
    guess(4'h2);
    chk("hint_l", Display, 8'hC7);
    chk("hint_l_err", 8'(Errors), 8'd2);
    guess(4'h5);
    chk("hint_done", 8'(A_Done), 8'd1);
    restart(4'h3);
    guess(4'h0);
    guess(4'hF);
    guess(4'h1);
    chk("lock", 8'(Locked_Out), 8'd1);
    chk("lock_disp", Display, 8'h8E);
    chk("lock_err", 8'(Errors), 8'd3);
    guess(4'h3);
    chk("lock_hold", 8'(Locked_Out), 8'd1);
    chk("lock_nodone", 8'(A_Done), 8'd0);
    chk("lock_err_hold", 8'(Errors), 8'd3);
    restart(4'h8);
    guess(4'h1);
    guess(4'h2);
    chk("pre_drop_err", 8'(Errors), 8'd2);
    Start = 1'b0;
    @(negedge Clk);
    chk("drop_err", 8'(Errors), 8'd0);
    chk("drop_disp", Display, 8'hFF);
    Switches_Attempt = 4'h7;
    Enter = 1'b1;
    @(negedge Clk);
    Enter = 1'b0;
    repeat (4) @(negedge Clk);
    chk("idle_press", 8'(Attempt), 8'd0);
    Start = 1'b1;
    @(negedge Clk);
    chk("rearm_dash", Display, 8'hBF);
    Switches_Attempt = 4'h8;
    Enter = 1'b1;
    @(negedge Clk);
    Enter = 1'b0;
    repeat (2) @(negedge Clk);
    Time_Over = 1'b1;
    @(negedge Clk);
    Time_Over = 1'b0;
    chk("to_lock", 8'(Locked_Out), 8'd1);
    chk("to_nodone", 8'(A_Done), 8'd0);
    chk("to_err", 8'(Errors), 8'd0);
    chk("to_nopulse", 8'(Wrong_Pulse), 8'd0);
    chk("to_disp", Display, 8'h8E);
    restart(4'h4);
    Switches_Attempt = 4'h1;
    Enter = 1'b1;
    repeat (100) @(negedge Clk);
    Enter = 1'b0;
    repeat (4) @(negedge Clk);
    chk("held_one_guess", 8'(Errors), 8'd1);
    for (int i = 0; i < 4000; i++) begin
      Reset = ($urandom_range(0, 199) == 0) || ((m_done || m_lock) && $urandom_range(0, 9) == 0);
      if (Start) Start = ($urandom_range(0, 59) != 0);
      else Start = ($urandom_range(0, 3) == 0);
      if (!Start) A_Pin = 4'($urandom);
      Time_Over = Start && ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 2) == 0) Enter = ~Enter;
      Switches_Attempt = ($urandom_range(0, 3) == 0) ? A_Pin : 4'($urandom);
      @(negedge Clk);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
